// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and helpers for the pipeline hazard unit.
//   sb_entry_t  : one scoreboard slot {valid, rd, wr, is_load} mirroring an
//                 in-flight stage after decode.
//   fwd_sel_w() : width of one fwd_sel channel (encodes 0..NUM_STAGES).
//   FWD_SEL_RF  : fwd_sel code meaning "take operand from the register file".
package hazard_pkg;

  // rd is stored at a fixed width so the entry can be a package-level type;
  // narrower register addresses are zero-extended into it.
  localparam int SB_RD_W    = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               is_load;
  } sb_entry_t;

  function automatic int fwd_sel_w(input int num_stages);
    return (num_stages < 2) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/inflight_sr.sv
// inflight_sr -- scoreboard shift register, one entry per stage after decode.
// Ports:
//   clk, rst      : clock, async active-high reset (clears every entry)
//   i_advance     : shift one position this cycle (low = pipeline frozen)
//   i_valid/i_rd/i_wr/i_is_load : information loaded into entry 1
//   o_entries     : entry k mirrors pipeline stage k (1 = EX ... N = WB)
module inflight_sr
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_advance,
  input  logic                       i_valid,
  input  logic [REG_ADDR_W-1:0]      i_rd,
  input  logic                       i_wr,
  input  logic                       i_is_load,
  output sb_entry_t [NUM_STAGES:1]   o_entries
);

  sb_entry_t [NUM_STAGES:1] r_sb;
  sb_entry_t                w_in;

  always_comb begin
    w_in         = '0;
    w_in.valid   = i_valid;
    w_in.rd      = SB_RD_W'(i_rd);
    w_in.wr      = i_wr;
    w_in.is_load = i_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb <= '0;
    end else if (i_advance) begin
      r_sb[1] <= w_in;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  assign o_entries = r_sb;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- data-hazard detection, forwarding select and stall control.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   id_valid                 : decode holds a real instruction
//   id_rs_addr / id_rs_used  : source addresses (channel i at bits i*W) / read flags
//   id_rd_addr / id_rd_wr    : destination address / writes-rd flag
//   id_is_load               : decode instruction is a load
//   flush                    : squash decode instruction (overrides hazard stall)
//   ext_stall                : freeze the whole pipeline
//   stall_id / bubble_ex     : hold PC+IF/ID / insert NOP into ID/EX
//   fwd_sel                  : per source, 0 = regfile, k = stage-k result
//   stall_cnt                : hazard stall cycles, wraps
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_EN     = 1,
  localparam int FSW       = fwd_sel_w(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_rd_wr,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic                          ext_stall,
  output logic                          stall_id,
  output logic                          bubble_ex,
  output logic [NUM_SRC*FSW-1:0]        fwd_sel,
  output logic [31:0]                   stall_cnt
);

  sb_entry_t [NUM_STAGES:1] w_sb;
  logic [NUM_SRC-1:0]       w_haz_src;
  logic [NUM_SRC*FSW-1:0]   w_fwd_sel;
  logic                     w_hazard;
  logic                     w_cnt_en;
  logic [31:0]              r_stall_cnt;

  inflight_sr #(
    .NUM_STAGES (NUM_STAGES),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_inflight_sr (
    .clk       (clk),
    .rst       (rst),
    .i_advance (~ext_stall),
    .i_valid   (id_valid & ~flush & ~w_hazard),
    .i_rd      (id_rd_addr),
    .i_wr      (id_rd_wr),
    .i_is_load (id_is_load),
    .o_entries (w_sb)
  );

  // Scan oldest to youngest so the last hit left standing is the youngest
  // writer (smallest stage index).
  always_comb begin : p_match
    logic [REG_ADDR_W-1:0] rs;
    logic [FSW-1:0]        young_k;
    logic                  young_ld;
    w_haz_src = '0;
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs       = id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      young_k  = FSW'(FWD_SEL_RF);
      young_ld = 1'b0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (id_valid && id_rs_used[i] && w_sb[k].valid && w_sb[k].wr &&
            (rs != '0) && (w_sb[k].rd == SB_RD_W'(rs))) begin
          young_k  = FSW'(k);
          young_ld = w_sb[k].is_load;
        end
      end
      if (FWD_EN != 0) begin
        // Load data not yet available at the youngest writer's stage.
        if ((young_k != FSW'(FWD_SEL_RF)) && young_ld && (int'(young_k) < LOAD_STAGE))
          w_haz_src[i] = 1'b1;
        else
          w_fwd_sel[i*FSW +: FSW] = young_k;
      end else begin
        if (young_k != FSW'(FWD_SEL_RF))
          w_haz_src[i] = 1'b1;
      end
    end
  end

  assign w_hazard = |w_haz_src;
  assign w_cnt_en = ~ext_stall & w_hazard & ~flush;

  // A flushed decode slot is being discarded anyway, so it never stalls.
  assign stall_id  = ext_stall | (w_hazard & ~flush);
  assign bubble_ex = ~ext_stall & (w_hazard | flush);
  assign fwd_sel   = w_fwd_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_en) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int RW  = 5;
  localparam int NS  = 2;
  localparam int FSW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [NS*RW-1:0] id_rs_addr;
  logic [NS-1:0]   id_rs_used;
  logic [RW-1:0]   id_rd_addr;
  logic            id_rd_wr, id_is_load, flush, ext_stall;

  logic            stall_f, bub_f, stall_n, bub_n;
  logic [NS*FSW-1:0] fwd_f, fwd_n;
  logic [31:0]     cnt_f, cnt_n;

  hazard_unit #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
    .stall_id(stall_f), .bubble_ex(bub_f), .fwd_sel(fwd_f), .stall_cnt(cnt_f)
  );

  hazard_unit #(.FWD_EN(0)) u_nof (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
    .stall_id(stall_n), .bubble_ex(bub_n), .fwd_sel(fwd_n), .stall_cnt(cnt_n)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic v; logic [RW-1:0] rs0, rs1; logic [1:0] used;
    logic [RW-1:0] rd; logic wr, ld, fl, es;
  } stim_t;

  typedef struct packed {
    logic stall; logic bub; logic [1:0] f1; logic [1:0] f0; logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic stim_t st(int v, int rs0, int rs1, int used, int rd,
                               int wr, int ld, int fl, int es);
    stim_t s;
    s.v = 1'(v); s.rs0 = RW'(rs0); s.rs1 = RW'(rs1); s.used = 2'(used);
    s.rd = RW'(rd); s.wr = 1'(wr); s.ld = 1'(ld); s.fl = 1'(fl); s.es = 1'(es);
    return s;
  endfunction

  function automatic exp_t ex(int s, int b, int f0, int f1, int c);
    return {1'(s), 1'(b), 2'(f1), 2'(f0), 32'(c)};
  endfunction

  task automatic apply(input stim_t s);
    id_valid   = s.v;
    id_rs_addr = {s.rs1, s.rs0};
    id_rs_used = s.used;
    id_rd_addr = s.rd;
    id_rd_wr   = s.wr;
    id_is_load = s.ld;
    flush      = s.fl;
    ext_stall  = s.es;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      if (r == 1) rst = 1'b0;
      exp_q.push_back(ex(0, 0, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset fwd row%0d got=%h exp=%h", r, got, e);
      end
      got = {stall_n, bub_n, fwd_n, cnt_n};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset nofwd row%0d got=%h exp=%h", r, got, e);
      end
      tick();
    end
  endtask

  task automatic test_fwd_alu();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 1, 2, 3, 5, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 5, 1, 3, 6, 1, 0, 0, 0)); x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(st(1, 6, 5, 3, 7, 1, 0, 0, 0)); x.push_back(ex(0, 0, 1, 2, 0));
    s.push_back(st(0, 6, 7, 3, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 6, 7, 3, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 3, 2, 0));
    foreach (s[r]) begin
      apply(s[r]);
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL fwd_alu row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 1, 0, 1, 5, 1, 1, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 5, 0, 3, 6, 1, 0, 0, 0)); x.push_back(ex(1, 1, 0, 0, 0));
    s.push_back(st(1, 5, 0, 3, 6, 1, 0, 0, 0)); x.push_back(ex(0, 0, 2, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 1));
    foreach (s[r]) begin
      apply(s[r]);
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_x0_priority();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 0, 0, 0, 0, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 3, 7, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 7, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 7, 0, 1, 7, 1, 0, 0, 0)); x.push_back(ex(0, 0, 2, 0, 0));
    s.push_back(st(1, 7, 7, 3, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 1, 1, 0));
    s.push_back(st(1, 7, 7, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 7, 2, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 3, 0));
    foreach (s[r]) begin
      apply(s[r]);
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL x0_priority row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_no_fwd();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 1, 2, 3, 5, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      s.push_back(st(1, 5, 0, 1, 6, 1, 0, 0, 0)); x.push_back(ex(1, 1, 0, 0, c));
    end
    s.push_back(st(1, 5, 0, 1, 6, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 3));
    s.push_back(st(0, 6, 0, 1, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 3));
    foreach (s[r]) begin
      apply(s[r]);
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_n, bub_n, fwd_n, cnt_n};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL no_fwd row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_flush_ext_stall();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 1, 0, 1, 5, 1, 1, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 5, 0, 1, 6, 1, 0, 1, 0)); x.push_back(ex(0, 1, 0, 0, 0));
    s.push_back(st(1, 5, 0, 1, 8, 1, 1, 0, 0)); x.push_back(ex(0, 0, 2, 0, 0));
    for (int c = 0; c < 4; c++) begin
      s.push_back(st(1, 8, 0, 1, 9, 1, 0, 0, 1)); x.push_back(ex(1, 0, 0, 0, 0));
    end
    s.push_back(st(1, 8, 0, 1, 9, 1, 0, 0, 0)); x.push_back(ex(1, 1, 0, 0, 0));
    s.push_back(st(1, 8, 0, 1, 9, 1, 0, 0, 0)); x.push_back(ex(0, 0, 2, 0, 1));
    foreach (s[r]) begin
      apply(s[r]);
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL flush_ext_stall row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[$]; exp_t x[$]; exp_t e, got;
    do_reset();
    s.push_back(st(1, 1, 0, 1, 5, 1, 1, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0));
    s.push_back(st(1, 5, 0, 1, 6, 1, 0, 0, 0)); x.push_back(ex(1, 1, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 9, 1, 1, 0, 0)); x.push_back(ex(0, 0, 0, 0, 1));
    // phase 3: load-use on x9 in progress, then rst pulsed between edges
    s.push_back(st(1, 9, 0, 1, 6, 1, 0, 0, 0)); x.push_back(ex(1, 1, 0, 0, 1));
    x.push_back(ex(0, 0, 0, 0, 0));
    x.push_back(ex(0, 0, 0, 0, 0));
    // after one edge the x6 writer sits in stage 1
    s.push_back(st(1, 6, 0, 1, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 1, 0, 0));
    for (int r = 0; r < x.size(); r++) begin
      if (r <= 3) apply(s[r]);
      else if (r == 6) apply(s[4]);
      if (r == 4) begin #2; rst = 1'b1; end
      if (r == 5) begin #2; rst = 1'b0; end
      exp_q.push_back(x[r]);
      #1;
      e = exp_q.pop_front();
      got = {stall_f, bub_f, fwd_f, cnt_f};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_stall row%0d got stall=%b bub=%b fwd=%h cnt=%0d exp stall=%b bub=%b fwd=%h cnt=%0d",
                 r, got.stall, got.bub, {got.f1, got.f0}, got.cnt, e.stall, e.bub, {e.f1, e.f0}, e.cnt);
      end
      if (r != 3 && r != 4) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_x0_priority();
    test_no_fwd();
    test_flush_ext_stall();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
